// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receiver: parity encodings, FSM states,
// baud-rate table and the tick-divider computation.
package uart_rx_fifo_pkg;

  localparam int unsigned ParNone = 0;
  localparam int unsigned ParEven = 1;
  localparam int unsigned ParOdd  = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  localparam int unsigned BaudTable [8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};

  // Clocks per 16x oversampling tick, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + 8 * baud) / (16 * baud);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_rx_baud_gen.sv
// 16x oversampling tick generator; divider reloads from the baud select
// and the phase restarts while the receiver is idle.
module rx_baud_gen
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] i_baud_sel,
  input  logic       i_idle,
  output logic       o_tick
);

  localparam int unsigned MaxDiv = calc_div(CLK_HZ, BaudTable[0]);
  localparam int unsigned DivW   = $clog2(MaxDiv + 1);

  logic [DivW-1:0] w_div_tab [8];
  logic [DivW-1:0] r_div;
  logic [DivW-1:0] r_cnt;
  logic            w_wrap;

  for (genvar g = 0; g < 8; g++) begin : g_tab
    localparam int unsigned Div = calc_div(CLK_HZ, BaudTable[g]);
    assign w_div_tab[g] = DivW'(Div);
  end

  assign w_wrap = (r_cnt == r_div - DivW'(1));
  assign o_tick = !i_idle && w_wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= DivW'(MaxDiv);
      r_cnt <= '0;
    end else if (i_idle) begin
      r_div <= w_div_tab[i_baud_sel];
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DivW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format; each frame and its error
// flags go into a first-word-fall-through FIFO with sticky overrun.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 1,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2:0]                    baud_select,
  input  logic                          Rx_EN,
  input  logic                          RxD,
  input  logic                          rd_en,
  input  logic                          clr_overrun,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_perror,
  output logic                          rx_ferror,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun
);

  localparam int unsigned AddrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned EntryW   = DATA_BITS + 2;
  localparam logic [3:0]  LastData = 4'(DATA_BITS - 1);
  localparam logic [3:0]  LastStop = 4'(STOP_BITS - 1);

  logic                 r_rxd_meta, r_rxd_sync;
  logic                 w_tick, w_idle;
  rx_state_e            r_state, w_state_nxt;
  logic [3:0]           r_tick_cnt, w_tick_nxt;
  logic [3:0]           r_bit_cnt, w_bit_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_perror, w_perror_nxt;
  logic                 r_ferror, w_ferror_nxt;
  logic                 r_wait_high, w_wait_high_nxt;
  logic                 r_push, w_push_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
    end else begin
      r_rxd_meta <= RxD;
      r_rxd_sync <= r_rxd_meta;
    end
  end

  assign w_idle = (r_state == StIdle);

  rx_baud_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_baud_gen (
    .clk       (clk),
    .reset     (reset),
    .i_baud_sel(baud_select),
    .i_idle    (w_idle),
    .o_tick    (w_tick)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_tick_nxt      = r_tick_cnt;
    w_bit_nxt       = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_perror_nxt    = r_perror;
    w_ferror_nxt    = r_ferror;
    w_wait_high_nxt = r_wait_high;
    w_push_nxt      = 1'b0;
    if (!Rx_EN) begin
      w_state_nxt = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          // After a framing error the line must be seen high before a new start.
          if (r_rxd_sync) begin
            w_wait_high_nxt = 1'b0;
          end else if (!r_wait_high) begin
            w_state_nxt = StStart;
            w_tick_nxt  = '0;
          end
        end
        StStart: begin
          if (w_tick) begin
            w_tick_nxt = r_tick_cnt + 4'd1;
            if (r_tick_cnt == 4'd7) begin
              if (r_rxd_sync) begin
                w_state_nxt = StIdle;
              end else begin
                w_state_nxt  = StData;
                w_tick_nxt   = '0;
                w_bit_nxt    = '0;
                w_perror_nxt = 1'b0;
                w_ferror_nxt = 1'b0;
              end
            end
          end
        end
        StData: begin
          if (w_tick) begin
            w_tick_nxt = r_tick_cnt + 4'd1;
            if (r_tick_cnt == 4'd15) begin
              w_shift_nxt = {r_rxd_sync, r_shift[DATA_BITS-1:1]};
              w_bit_nxt   = r_bit_cnt + 4'd1;
              if (r_bit_cnt == LastData) begin
                w_bit_nxt   = '0;
                w_state_nxt = (PARITY_MODE == ParNone) ? StStop : StParity;
              end
            end
          end
        end
        StParity: begin
          if (w_tick) begin
            w_tick_nxt = r_tick_cnt + 4'd1;
            if (r_tick_cnt == 4'd15) begin
              w_perror_nxt = r_rxd_sync != ((PARITY_MODE == ParOdd) ? ~^r_shift : ^r_shift);
              w_state_nxt  = StStop;
            end
          end
        end
        StStop: begin
          if (w_tick) begin
            w_tick_nxt = r_tick_cnt + 4'd1;
            if (r_tick_cnt == 4'd15) begin
              w_ferror_nxt = r_ferror | !r_rxd_sync;
              w_bit_nxt    = r_bit_cnt + 4'd1;
              if (r_bit_cnt == LastStop) begin
                w_push_nxt      = 1'b1;
                w_state_nxt     = StIdle;
                w_wait_high_nxt = r_ferror | !r_rxd_sync;
              end
            end
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_perror    <= 1'b0;
      r_ferror    <= 1'b0;
      r_wait_high <= 1'b0;
      r_push      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tick_cnt  <= w_tick_nxt;
      r_bit_cnt   <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_perror    <= w_perror_nxt;
      r_ferror    <= w_ferror_nxt;
      r_wait_high <= w_wait_high_nxt;
      r_push      <= w_push_nxt;
    end
  end

  logic [EntryW-1:0] r_mem [FIFO_DEPTH];
  logic [AddrW:0]    r_wptr, r_rptr;
  logic [AddrW:0]    w_count;
  logic              w_empty, w_full, w_pop, w_wr, w_drop;
  logic [EntryW-1:0] w_head;
  logic              r_overrun;

  assign w_count = r_wptr - r_rptr;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == (AddrW + 1)'(FIFO_DEPTH));
  assign w_pop   = rd_en && !w_empty;
  // Pop is applied first, so a full FIFO being read still accepts the push.
  assign w_wr    = r_push && (!w_full || w_pop);
  assign w_drop  = r_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr[AddrW-1:0]] <= {r_ferror, r_perror, r_shift};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + (AddrW + 1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (AddrW + 1)'(1);
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (clr_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign w_head     = r_mem[r_rptr[AddrW-1:0]];
  assign rx_data    = w_empty ? '0 : w_head[DATA_BITS-1:0];
  assign rx_perror  = !w_empty && w_head[DATA_BITS];
  assign rx_ferror  = !w_empty && w_head[DATA_BITS+1];
  assign rx_valid   = !w_empty;
  assign fifo_count = w_count;
  assign overrun    = r_overrun;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with configurable frame format and a receive FIFO. It sits between the asynchronous RxD pin and the character consumer (display or host logic). It oversamples RxD at 16x the selected baud rate and checks parity and stop bits. Each frame is buffered with its error flags, so bursts of back-to-back characters are not lost.

## Interface
- CLK_HZ, 50_000_000, system clock frequency.
- DATA_BITS, 8, data bits per frame, 5..9, LSB first.
- PARITY_MODE, 1, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, 1 or 2.
- FIFO_DEPTH, 4, entries; power of two, ≥2.
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- baud_select  in  3  000..111 → 300, 1200, 4800, 9600, 19200, 38400, 57600, 115200 baud.
- Rx_EN  in  1  receiver enable.
- RxD  in  1  serial line, idle high, asynchronous.
- rd_en  in  1  pop FIFO head.
- clr_overrun  in  1  clears sticky overrun.
- rx_data  out  DATA_BITS  FIFO head data (first-word fall-through).
- rx_perror  out  1  parity error flag of the head entry.
- rx_ferror  out  1  framing error flag of the head entry.
- rx_valid  out  1  FIFO non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held.
- overrun  out  1  sticky; a frame was dropped because the FIFO was full.

## Operation
- RxD passes through a 2-FF synchroniser, reset to 1; all logic uses the synchronised value.
- Tick generator: period D = round(CLK_HZ/(16·baud)) clocks, one-cycle tick pulse. D is reloaded from baud_select only while the FSM is in IDLE.
- FSM states: IDLE, START, DATA, PARITY, STOP. A 4-bit tick counter and a bit counter control progress.
  - IDLE: a low synchronised RxD moves the FSM to START and clears the tick counter.
  - START: on the 8th tick (mid-bit), resample the line.
    - Line high: false start; return to IDLE with no push.
    - Line low: go to DATA.
  - DATA: sample every 16 ticks (mid-bit); shift right into a DATA_BITS register. After DATA_BITS samples, go to PARITY, or to STOP when PARITY_MODE=0.
  - PARITY: sample once. perror = sample ≠ expected, where expected = ^data for even and ~^data for odd.
  - STOP: sample STOP_BITS times. ferror = any sampled stop bit is 0.
    - After the last stop sample, push {ferror, perror, data} and return to IDLE.
    - With ferror=1, IDLE does not detect a new start until the line has been sampled high once.
- With PARITY_MODE=0, perror is always 0.
- FIFO: circular buffer with read/write pointers one bit wider than the address.
  - A push when full drops the frame and sets overrun. Contents are unchanged.
  - rd_en with rx_valid=0 is ignored.
  - Simultaneous push and pop: pop takes effect first, so a push into a full FIFO succeeds and the count is unchanged.
  - Simultaneous set and clr_overrun: set wins.
- Rx_EN=0: the FSM returns to IDLE on the next clock and any partial frame is discarded. FIFO, overrun and the read side remain operational.
- Reset: FSM in IDLE, FIFO emptied.
  - All outputs reset to 0: rx_data, rx_perror, rx_ferror, rx_valid, fifo_count, overrun.
  - Reset asserted mid-frame aborts the frame with no push.

## Timing
- The push occurs in the clock after the final stop-bit sample tick. rx_valid, fifo_count and rx_data update one cycle after the push.
- A pop is visible the next cycle: rx_data shows the new head, or rx_valid goes low.
- RxD-to-FSM latency: 2 clocks through the synchroniser.
- Sampling instant: 8 + 16·k ticks after start detection, ±1 tick of quantisation.
- Example: at 50 MHz and 115200 baud, D=27 and one bit lasts 432 clocks (8640 ns).

## Structure
- A shared package holds:
  - the parity-mode encodings;
  - the FSM state enum;
  - the baud_select-to-baud-rate table;
  - a function computing D from CLK_HZ and the baud rate.
- Sub-module rx_baud_gen (tick generator, parameter CLK_HZ). FSM, shift register and FIFO stay in uart_rx_fifo.

## Test plan
- Reset held for 400 ns with RxD=1: all outputs 0 and no push for 20 bit-times.
- 115200 baud, even parity: frame 0x85 with parity 1 → rx_data=0x85, rx_perror=0, rx_ferror=0, fifo_count=1; one rd_en → rx_valid=0.
- Frame 0xC4 with parity bit 0 (even expects 1) → rx_data=0xC4, rx_perror=1. Same frame with stop bit 0 → rx_ferror=1.
- FIFO_DEPTH=4: five back-to-back frames 0x01..0x05 with no reads → fifo_count=4, overrun=1, and the pop order is 0x01..0x04. clr_overrun → overrun=0.
- RxD low pulse of 4 ticks → false start, no push. Rx_EN dropped during D3 of a frame → no push; the next full frame with Rx_EN=1 is received correctly.
- DATA_BITS=7, PARITY_MODE=2, STOP_BITS=2 at 9600 baud: frame 0x5A → rx_data=0x5A with correct odd-parity checking; a zero in the second stop bit → rx_ferror=1.
